axi_lite_decoder_1ton: RTL and testbench

- Parametrised AXI4-Lite 1-master-to-N-slave address decoder/router with registered routing state.
- Sits between the picorv32_axi master and the memory-mapped slaves (SRAM wrapper, top_aes, future peripherals).
- Replaces the open-coded per-slave select/mux glue in the system top with one block.
- Adds:
  - independent read and write FSMs, one outstanding transaction each;
  - select latched for the whole transaction;
  - read data muxed by latched select;
  - DECERR completion for unmapped addresses.

---
 rtl/axi_lite_decoder_1ton_if.sv | 61 ++++++
 rtl/axi_lite_decoder_1ton.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_decoder_1ton.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_decoder_1ton_if.sv
// Bus bundle for the 1-to-N AXI4-Lite decoder: upstream master channel (s_*) and broadcast/per-slave downstream channel (m_*).
// Modport "master" is the decoder's view (it masters the downstream slaves); "slave" is the surrounding environment's view.
interface axi_lite_decoder_1ton_if #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [ADDR_W-1:0]            s_awaddr;
    logic                         s_awvalid;
    logic                         s_awready;
    logic [DATA_W-1:0]            s_wdata;
    logic [DATA_W/8-1:0]          s_wstrb;
    logic                         s_wvalid;
    logic                         s_wready;
    logic [1:0]                   s_bresp;
    logic                         s_bvalid;
    logic                         s_bready;
    logic [ADDR_W-1:0]            s_araddr;
    logic                         s_arvalid;
    logic                         s_arready;
    logic [DATA_W-1:0]            s_rdata;
    logic [1:0]                   s_rresp;
    logic                         s_rvalid;
    logic                         s_rready;

    logic [ADDR_W-1:0]            m_awaddr;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W/8-1:0]          m_wstrb;
    logic [ADDR_W-1:0]            m_araddr;
    logic [NUM_SLAVES-1:0]        m_awvalid;
    logic [NUM_SLAVES-1:0]        m_awready;
    logic [NUM_SLAVES-1:0]        m_wvalid;
    logic [NUM_SLAVES-1:0]        m_wready;
    logic [NUM_SLAVES-1:0]        m_arvalid;
    logic [NUM_SLAVES-1:0]        m_arready;
    logic [NUM_SLAVES-1:0]        m_bvalid;
    logic [NUM_SLAVES-1:0]        m_bready;
    logic [NUM_SLAVES-1:0]        m_rvalid;
    logic [NUM_SLAVES-1:0]        m_rready;
    logic [NUM_SLAVES*2-1:0]      m_bresp;
    logic [NUM_SLAVES*2-1:0]      m_rresp;
    logic [NUM_SLAVES*DATA_W-1:0] m_rdata;

    modport master (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
        output m_awaddr, m_wdata, m_wstrb, m_araddr,
        output m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
        input  m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_bresp, m_rresp, m_rdata
    );

    modport slave (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
        input  m_awaddr, m_wdata, m_wstrb, m_araddr,
        input  m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
        output m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_bresp, m_rresp, m_rdata
    );
endinterface

// File: rtl/axi_lite_decoder_1ton.sv
// AXI4-Lite 1-master-to-N-slave decoder with latched per-transaction select and independent read/write FSMs.
// Optional watchdog (SLVERR on stuck slave, sticky timeout_err, late-response absorption) enabled by AXIL_DEC_TIMEOUT_EN.
module axi_lite_decoder_1ton #(
    parameter int                          NUM_SLAVES     = 2,
    parameter int                          ADDR_W         = 32,
    parameter int                          DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS    = {32'h0000_0300, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS    = {32'hFFFF_FF00, 32'hFFFF_FE00},
    parameter int                          TIMEOUT_CYCLES = 256
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi_lite_decoder_1ton_if.master  bus,
    output logic                     timeout_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("axi_lite_decoder_1ton: unsupported NUM_SLAVES or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_state_t;

    // Lowest index wins on overlapping windows: scan downwards so the last hit is the smallest index.
    function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
        logic [SEL_W:0] res;
        res = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) == BASE_ADDRS[i*ADDR_W +: ADDR_W])
                res = {1'b1, SEL_W'(i)};
        end
        return res;
    endfunction

    w_state_t              w_state_q, w_state_d;
    r_state_t              r_state_q, r_state_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [SEL_W-1:0]      wsel_q, wsel_d, rsel_q, rsel_d;
    logic                  whit_q, whit_d, rhit_q, rhit_d;
    logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                  m_awv_q, m_awv_d, m_wv_q, m_wv_d, m_arv_q, m_arv_d;
    logic                  s_bvalid_c, s_rvalid_c;
    logic [1:0]            s_bresp_c, s_rresp_c, w_err_resp, r_err_resp;
    logic [DATA_W-1:0]     s_rdata_c;
    logic [NUM_SLAVES-1:0] w_bready, r_rready, wstale, rstale;

`ifdef AXIL_DEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic                  wto_q, wto_d, rto_q, rto_d, w_to_evt, r_to_evt;
    logic [NUM_SLAVES-1:0] wstale_q, wstale_d, rstale_q, rstale_d;
    logic                  timeout_err_q, timeout_err_d;
    assign w_err_resp  = wto_q ? 2'b10 : 2'b11;
    assign r_err_resp  = rto_q ? 2'b10 : 2'b11;
    assign wstale      = wstale_q;
    assign rstale      = rstale_q;
    assign timeout_err = timeout_err_q;
`else
    assign w_err_resp  = 2'b11;
    assign r_err_resp  = 2'b11;
    assign wstale      = '0;
    assign rstale      = '0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_d  = w_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wsel_d     = wsel_q;
        whit_d     = whit_q;
        m_awv_d    = m_awv_q;
        m_wv_d     = m_wv_q;
        s_bvalid_c = 1'b0;
        s_bresp_c  = 2'b00;
        w_bready   = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (bus.s_awvalid && awready_q) begin
                    aw_got_d         = 1'b1;
                    awaddr_d         = bus.s_awaddr;
                    {whit_d, wsel_d} = decode(bus.s_awaddr);
                end
                if (bus.s_wvalid && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = bus.s_wdata;
                    wstrb_d = bus.s_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (whit_d) begin
                        w_state_d = W_FWD;
                        m_awv_d   = 1'b1;
                        m_wv_d    = 1'b1;
                    end else begin
                        w_state_d = W_ERR;
                    end
                end
            end
            W_FWD: begin
                if (m_awv_q && bus.m_awready[wsel_q]) m_awv_d = 1'b0;
                if (m_wv_q && bus.m_wready[wsel_q])   m_wv_d  = 1'b0;
                if (!m_awv_d && !m_wv_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_bvalid_c       = bus.m_bvalid[wsel_q];
                s_bresp_c        = bus.m_bresp[int'(wsel_q)*2 +: 2];
                w_bready[wsel_q] = bus.s_bready;
                if (s_bvalid_c && bus.s_bready) w_state_d = W_IDLE;
            end
            default: begin
                s_bvalid_c = 1'b1;
                s_bresp_c  = w_err_resp;
                if (bus.s_bready) w_state_d = W_IDLE;
            end
        endcase
`ifdef AXIL_DEC_TIMEOUT_EN
        w_to_evt = 1'b0;
        wto_d    = (w_state_q == W_ERR && w_state_d == W_IDLE) ? 1'b0 : wto_q;
        wstale_d = wstale_q & ~bus.m_bvalid;
        if ((w_state_q == W_FWD || w_state_q == W_RESP) && w_state_d == w_state_q &&
            wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_d        = W_ERR;
            m_awv_d          = 1'b0;
            m_wv_d           = 1'b0;
            wto_d            = 1'b1;
            wstale_d[wsel_q] = 1'b1;
            w_to_evt         = 1'b1;
        end
        if (w_state_d != w_state_q)                         wcnt_d = '0;
        else if (w_state_q == W_FWD || w_state_q == W_RESP) wcnt_d = wcnt_q + CNT_W'(1);
        else                                                wcnt_d = '0;
`endif
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    always_comb begin
        r_state_d  = r_state_q;
        araddr_d   = araddr_q;
        rsel_d     = rsel_q;
        rhit_d     = rhit_q;
        m_arv_d    = m_arv_q;
        s_rvalid_c = 1'b0;
        s_rresp_c  = 2'b00;
        s_rdata_c  = '0;
        r_rready   = '0;
        unique case (r_state_q)
            R_IDLE: begin
                if (bus.s_arvalid && arready_q) begin
                    araddr_d         = bus.s_araddr;
                    {rhit_d, rsel_d} = decode(bus.s_araddr);
                    if (rhit_d) begin
                        r_state_d = R_FWD;
                        m_arv_d   = 1'b1;
                    end else begin
                        r_state_d = R_ERR;
                    end
                end
            end
            R_FWD: begin
                if (bus.m_arready[rsel_q]) begin
                    m_arv_d   = 1'b0;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                // Data/resp follow the latched select only, so a stray rvalid elsewhere cannot leak through.
                s_rvalid_c       = bus.m_rvalid[rsel_q];
                s_rresp_c        = bus.m_rresp[int'(rsel_q)*2 +: 2];
                s_rdata_c        = bus.m_rdata[int'(rsel_q)*DATA_W +: DATA_W];
                r_rready[rsel_q] = bus.s_rready;
                if (s_rvalid_c && bus.s_rready) r_state_d = R_IDLE;
            end
            default: begin
                s_rvalid_c = 1'b1;
                s_rresp_c  = r_err_resp;
                if (bus.s_rready) r_state_d = R_IDLE;
            end
        endcase
`ifdef AXIL_DEC_TIMEOUT_EN
        r_to_evt = 1'b0;
        rto_d    = (r_state_q == R_ERR && r_state_d == R_IDLE) ? 1'b0 : rto_q;
        rstale_d = rstale_q & ~bus.m_rvalid;
        if ((r_state_q == R_FWD || r_state_q == R_RESP) && r_state_d == r_state_q &&
            rcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state_d        = R_ERR;
            m_arv_d          = 1'b0;
            rto_d            = 1'b1;
            rstale_d[rsel_q] = 1'b1;
            r_to_evt         = 1'b1;
        end
        if (r_state_d != r_state_q)                         rcnt_d = '0;
        else if (r_state_q == R_FWD || r_state_q == R_RESP) rcnt_d = rcnt_q + CNT_W'(1);
        else                                                rcnt_d = '0;
        timeout_err_d = timeout_err_q | w_to_evt | r_to_evt;
`endif
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wsel_q    <= '0;
            rsel_q    <= '0;
            whit_q    <= 1'b0;
            rhit_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            m_awv_q   <= 1'b0;
            m_wv_q    <= 1'b0;
            m_arv_q   <= 1'b0;
`ifdef AXIL_DEC_TIMEOUT_EN
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            wto_q         <= 1'b0;
            rto_q         <= 1'b0;
            wstale_q      <= '0;
            rstale_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wsel_q    <= wsel_d;
            rsel_q    <= rsel_d;
            whit_q    <= whit_d;
            rhit_q    <= rhit_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            m_awv_q   <= m_awv_d;
            m_wv_q    <= m_wv_d;
            m_arv_q   <= m_arv_d;
`ifdef AXIL_DEC_TIMEOUT_EN
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            wto_q         <= wto_d;
            rto_q         <= rto_d;
            wstale_q      <= wstale_d;
            rstale_q      <= rstale_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign bus.s_awready = awready_q;
    assign bus.s_wready  = wready_q;
    assign bus.s_arready = arready_q;
    assign bus.s_bvalid  = s_bvalid_c;
    assign bus.s_bresp   = s_bresp_c;
    assign bus.s_rvalid  = s_rvalid_c;
    assign bus.s_rresp   = s_rresp_c;
    assign bus.s_rdata   = s_rdata_c;
    assign bus.m_awaddr  = awaddr_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_araddr  = araddr_q;
    assign bus.m_awvalid = {NUM_SLAVES{m_awv_q}} & (NUM_SLAVES'(1) << wsel_q);
    assign bus.m_wvalid  = {NUM_SLAVES{m_wv_q}}  & (NUM_SLAVES'(1) << wsel_q);
    assign bus.m_arvalid = {NUM_SLAVES{m_arv_q}} & (NUM_SLAVES'(1) << rsel_q);
    // Stale slaves get a forced ready so one late response is drained instead of hanging them.
    assign bus.m_bready  = w_bready | wstale;
    assign bus.m_rready  = r_rready | rstale;
endmodule

// File: tb/tb_axi_lite_decoder_1ton.sv
// Directed bench for axi_lite_decoder_1ton: write/read routing, decode miss, split AW/W, back-pressure, reset abort.
module tb_axi_lite_decoder_1ton;
`ifdef AXIL_DEC_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 256;
`endif

    logic aclk;
    logic aresetn;
    logic timeout_err;
    int   checks;
    int   errors;

    axi_lite_decoder_1ton_if #(.NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_decoder_1ton #(
        .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32),
        .BASE_ADDRS({32'h0000_0300, 32'h0000_0000}),
        .ADDR_MASKS({32'hFFFF_FF00, 32'hFFFF_FE00}),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .timeout_err(timeout_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        aresetn = 1'b0;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0; bus.m_awready = '0; bus.m_wready = '0; bus.m_arready = '0;
        bus.m_bvalid = '0; bus.m_rvalid = '0; bus.m_bresp = '0; bus.m_rresp = '0; bus.m_rdata = '0;

        // Reset state
        repeat (3) cyc();
        #1;
        chk("rst_awready", bus.s_awready, 0);
        chk("rst_wready", bus.s_wready, 0);
        chk("rst_arready", bus.s_arready, 0);
        chk("rst_bvalid", bus.s_bvalid, 0);
        chk("rst_rvalid", bus.s_rvalid, 0);
        chk("rst_m_awvalid", bus.m_awvalid, 0);
        chk("rst_rdata", bus.s_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        aresetn = 1'b1;
        cyc();
        #1;
        chk("idle_awready", bus.s_awready, 1);
        chk("idle_wready", bus.s_wready, 1);
        chk("idle_arready", bus.s_arready, 1);

        // Write 0x10 to slave 0, AW and W together
        bus.s_awaddr = 32'h10; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'hDEADBEEF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        cyc();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.m_awready = 2'b01;
        #1;
        chk("w1_m_awvalid", bus.m_awvalid, 2'b01);
        chk("w1_m_wvalid", bus.m_wvalid, 2'b01);
        chk("w1_m_awaddr", bus.m_awaddr, 32'h10);
        chk("w1_m_wdata", bus.m_wdata, 32'hDEADBEEF);
        chk("w1_m_wstrb", bus.m_wstrb, 4'hF);
        chk("w1_awready_busy", bus.s_awready, 0);
        cyc();
        bus.m_awready = 2'b00; bus.m_wready = 2'b01;
        #1;
        chk("w1_aw_dropped", bus.m_awvalid, 2'b00);
        chk("w1_w_held", bus.m_wvalid, 2'b01);
        cyc();
        bus.m_wready = 2'b00; bus.m_bvalid = 2'b01; bus.m_bresp = {2'b10, 2'b00}; bus.s_bready = 1'b0;
        #1;
        chk("w1_w_dropped", bus.m_wvalid, 2'b00);
        chk("w1_bvalid", bus.s_bvalid, 1);
        chk("w1_bresp", bus.s_bresp, 2'b00);
        chk("w1_bready_held", bus.m_bready, 2'b00);
        cyc();
        bus.s_bready = 1'b1;
        #1;
        chk("w1_bvalid_stable", bus.s_bvalid, 1);
        chk("w1_m_bready", bus.m_bready, 2'b01);
        cyc();
        bus.m_bvalid = 2'b00; bus.s_bready = 1'b0;
        #1;
        chk("w1_done_bvalid", bus.s_bvalid, 0);
        chk("w1_done_awready", bus.s_awready, 1);

        // Read 0x304 from slave 1 while slave 0 glitches rvalid
        bus.s_araddr = 32'h304; bus.s_arvalid = 1'b1;
        cyc();
        bus.s_arvalid = 1'b0;
        #1;
        chk("r1_m_arvalid", bus.m_arvalid, 2'b10);
        chk("r1_m_araddr", bus.m_araddr, 32'h304);
        chk("r1_arready_busy", bus.s_arready, 0);
        bus.m_arready = 2'b10;
        cyc();
        bus.m_arready = 2'b00; bus.m_rvalid = 2'b01; bus.s_rready = 1'b1;
        bus.m_rdata = {32'h12345678, 32'hAAAA5555}; bus.m_rresp = {2'b00, 2'b11};
        #1;
        chk("r1_glitch_rvalid", bus.s_rvalid, 0);
        chk("r1_glitch_rdata", bus.s_rdata, 32'h12345678);
        chk("r1_m_rready", bus.m_rready, 2'b10);
        cyc();
        bus.m_rvalid = 2'b10;
        #1;
        chk("r1_rvalid", bus.s_rvalid, 1);
        chk("r1_rdata", bus.s_rdata, 32'h12345678);
        chk("r1_rresp", bus.s_rresp, 2'b00);
        cyc();
        bus.m_rvalid = 2'b00; bus.s_rready = 1'b0;
        #1;
        chk("r1_done_rvalid", bus.s_rvalid, 0);
        chk("r1_done_rdata", bus.s_rdata, 0);
        chk("r1_done_arready", bus.s_arready, 1);

        // Unmapped write 0x250 -> DECERR
        bus.s_awaddr = 32'h250; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h1; bus.s_wstrb = 4'h1; bus.s_wvalid = 1'b1;
        cyc();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        #1;
        chk("e1_m_awvalid", bus.m_awvalid, 2'b00);
        chk("e1_m_wvalid", bus.m_wvalid, 2'b00);
        chk("e1_bvalid", bus.s_bvalid, 1);
        chk("e1_bresp", bus.s_bresp, 2'b11);
        cyc();
        #1;
        chk("e1_bvalid_held", bus.s_bvalid, 1);
        chk("e1_bresp_held", bus.s_bresp, 2'b11);
        bus.s_bready = 1'b1;
        cyc();
        bus.s_bready = 1'b0;
        #1;
        chk("e1_done_bvalid", bus.s_bvalid, 0);

        // W three cycles before AW, with a concurrent read to slave 1
        bus.s_wdata = 32'hCAFEF00D; bus.s_wstrb = 4'h3; bus.s_wvalid = 1'b1;
        bus.s_araddr = 32'h3F0; bus.s_arvalid = 1'b1;
        cyc();
        bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        #1;
        chk("c1_wready_busy", bus.s_wready, 0);
        chk("c1_awready_open", bus.s_awready, 1);
        chk("c1_m_wvalid_wait", bus.m_wvalid, 2'b00);
        chk("c1_m_arvalid", bus.m_arvalid, 2'b10);
        bus.m_arready = 2'b10;
        cyc();
        bus.m_arready = 2'b00; bus.m_rvalid = 2'b10; bus.s_rready = 1'b1;
        bus.m_rdata = {32'h0BADF00D, 32'h0};
        #1;
        chk("c1_rvalid", bus.s_rvalid, 1);
        chk("c1_rdata", bus.s_rdata, 32'h0BADF00D);
        cyc();
        bus.m_rvalid = 2'b00; bus.s_rready = 1'b0;
        bus.s_awaddr = 32'h1FC; bus.s_awvalid = 1'b1;
        #1;
        chk("c1_r_done", bus.s_rvalid, 0);
        cyc();
        bus.s_awvalid = 1'b0;
        #1;
        chk("c1_m_awvalid", bus.m_awvalid, 2'b01);
        chk("c1_m_wvalid", bus.m_wvalid, 2'b01);
        chk("c1_m_awaddr", bus.m_awaddr, 32'h1FC);
        chk("c1_m_wdata", bus.m_wdata, 32'hCAFEF00D);
        chk("c1_m_wstrb", bus.m_wstrb, 4'h3);
        bus.m_awready = 2'b01; bus.m_wready = 2'b01;
        cyc();
        bus.m_awready = 2'b00; bus.m_wready = 2'b00;
        bus.m_bvalid = 2'b01; bus.m_bresp = {2'b00, 2'b10}; bus.s_bready = 1'b1;
        #1;
        chk("c1_bvalid", bus.s_bvalid, 1);
        chk("c1_bresp", bus.s_bresp, 2'b10);
        cyc();
        bus.m_bvalid = 2'b00; bus.s_bready = 1'b0;
        #1;
        chk("c1_done_bvalid", bus.s_bvalid, 0);

`ifdef AXIL_DEC_TIMEOUT_EN
        // Slave 1 never answers a read -> SLVERR after TIMEOUT_CYCLES, then late rvalid is absorbed
        bus.s_araddr = 32'h304; bus.s_arvalid = 1'b1; bus.m_arready = 2'b10;
        cyc();
        bus.s_arvalid = 1'b0;
        #1;
        chk("t1_m_arvalid", bus.m_arvalid, 2'b10);
        cyc();
        bus.m_arready = 2'b00;
        repeat (15) cyc();
        #1;
        chk("t1_still_waiting", bus.s_rvalid, 0);
        cyc();
        #1;
        chk("t1_rvalid", bus.s_rvalid, 1);
        chk("t1_rresp", bus.s_rresp, 2'b10);
        chk("t1_rdata", bus.s_rdata, 0);
        chk("t1_timeout_err", timeout_err, 1);
        chk("t1_stale_rready", bus.m_rready, 2'b10);
        bus.s_rready = 1'b1;
        cyc();
        bus.s_rready = 1'b0; bus.m_rvalid = 2'b10;
        #1;
        chk("t1_absorb_rready", bus.m_rready, 2'b10);
        chk("t1_absorb_no_rvalid", bus.s_rvalid, 0);
        cyc();
        bus.m_rvalid = 2'b00;
        #1;
        chk("t1_stale_cleared", bus.m_rready, 2'b00);
        chk("t1_sticky", timeout_err, 1);
`else
        chk("no_timeout_err", timeout_err, 0);
`endif

        // Reset asserted while in W_RESP
        bus.s_awaddr = 32'h20; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h11; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        cyc();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        bus.m_awready = 2'b01; bus.m_wready = 2'b01;
        cyc();
        bus.m_awready = 2'b00; bus.m_wready = 2'b00; bus.m_bvalid = 2'b01; bus.m_bresp = '0;
        #1;
        chk("x1_bvalid_pre", bus.s_bvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("x1_bvalid_rst", bus.s_bvalid, 0);
        chk("x1_bready_rst", bus.m_bready, 2'b00);
        chk("x1_awready_rst", bus.s_awready, 0);
        chk("x1_awaddr_rst", bus.m_awaddr, 0);
        chk("x1_wdata_rst", bus.m_wdata, 0);
        bus.m_bvalid = 2'b00;
        cyc();
        aresetn = 1'b1;
        cyc();
        #1;
        chk("x1_awready_after", bus.s_awready, 1);
        bus.s_awaddr = 32'h30; bus.s_awvalid = 1'b1;
        bus.s_wdata = 32'h55; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        cyc();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        #1;
        chk("x2_m_awvalid", bus.m_awvalid, 2'b01);
        chk("x2_m_awaddr", bus.m_awaddr, 32'h30);
        chk("x2_m_wdata", bus.m_wdata, 32'h55);
        bus.m_awready = 2'b01; bus.m_wready = 2'b01;
        cyc();
        bus.m_awready = 2'b00; bus.m_wready = 2'b00; bus.m_bvalid = 2'b01; bus.s_bready = 1'b1;
        #1;
        chk("x2_bvalid", bus.s_bvalid, 1);
        chk("x2_bresp", bus.s_bresp, 2'b00);
        cyc();
        bus.m_bvalid = 2'b00; bus.s_bready = 1'b0;
        #1;
        chk("x2_done_bvalid", bus.s_bvalid, 0);
        chk("x2_done_awready", bus.s_awready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
